// File: rtl/pc_stack_unit.sv
// ============================================================================
// Module  : pc_stack_unit
// Brief   : Program counter with relative branch, stall enable and a hardware
//           return-address stack for call/ret, with sticky ovf/unf flags.
//           Define PC_STACK_WRAP_EN to make the stack circular on overflow.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_stack_unit #(
  parameter int            AW        = 5,
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       ld_pc,
  input  logic                       br_pc,
  input  logic                       inc_pc,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       clr_err,
  input  logic [AW-1:0]              pc_in,
  input  logic [AW-1:0]              offset,
  output logic [AW-1:0]              pc_out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] C_SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] C_SP_ONE  = SPW'(1);

  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic           r_ovf;
  logic           r_unf;
  logic [AW-1:0]  r_stack [DEPTH];

  logic [AW-1:0]  w_pc_nxt;
  logic [AW-1:0]  w_pc_inc;
  logic [SPW-1:0] w_sp_nxt;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_ovf_set;
  logic           w_unf_set;
  logic [PW-1:0]  w_push_idx;
  logic [PW-1:0]  w_top_idx;

  assign w_pc_inc = r_pc + AW'(1);
  assign w_full   = (r_sp == C_SP_FULL);
  assign w_empty  = (r_sp == '0);

`ifdef PC_STACK_WRAP_EN
  // Circular stack: r_bot marks the oldest entry; a full push overwrites it.
  logic [PW-1:0] r_bot;
  logic          w_bot_adv;

  function automatic logic [PW-1:0] f_wrap(input logic [PW:0] a);
    if (a >= (PW+1)'(DEPTH)) f_wrap = PW'(a - (PW+1)'(DEPTH));
    else                     f_wrap = PW'(a);
  endfunction

  assign w_push_idx = f_wrap((PW+1)'(r_bot) + (PW+1)'(r_sp));
  assign w_top_idx  = f_wrap((PW+1)'(r_bot) + (PW+1)'(r_sp) - (PW+1)'(1));
  assign w_bot_adv  = en && !ret && call && w_full;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_bot <= '0;
    else if (w_bot_adv) r_bot <= f_wrap((PW+1)'(r_bot) + (PW+1)'(1));
  end
`else
  assign w_push_idx = PW'(r_sp);
  assign w_top_idx  = PW'(r_sp - C_SP_ONE);
`endif

  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (en) begin
      if (ret) begin
        if (!w_empty) begin
          w_pc_nxt = r_stack[w_top_idx];
          w_sp_nxt = r_sp - C_SP_ONE;
        end else begin
          // Empty ret degrades to an increment so the core keeps moving.
          w_pc_nxt  = w_pc_inc;
          w_unf_set = 1'b1;
        end
      end else if (call) begin
        w_pc_nxt = pc_in;
        if (!w_full) begin
          w_push   = 1'b1;
          w_sp_nxt = r_sp + C_SP_ONE;
        end else begin
          w_ovf_set = 1'b1;
`ifdef PC_STACK_WRAP_EN
          w_push = 1'b1;
`endif
        end
      end else if (ld_pc) begin
        w_pc_nxt = pc_in;
      end else if (br_pc) begin
        w_pc_nxt = r_pc + offset;
      end else if (inc_pc) begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc  <= RESET_VEC;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      r_sp <= w_sp_nxt;
      // Error set takes precedence over a same-cycle clear.
      r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
      r_unf <= w_unf_set | (r_unf & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign pc_out      = r_pc;
  assign sp          = r_sp;
  assign ovf         = r_ovf;
  assign unf         = r_unf;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
// ============================================================================
// Module  : tb_pc_stack_unit
// Brief   : Directed scoreboard bench for pc_stack_unit (AW=5, DEPTH=4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_stack_unit;

  localparam int AW = 5;
  localparam int DEPTH = 4;

  // Strobe word bits: {rst_n, en, ret, call, ld_pc, br_pc, inc_pc, clr_err}
  localparam logic [7:0] N  = 8'h80;
  localparam logic [7:0] E  = 8'h40;
  localparam logic [7:0] RT = 8'h20;
  localparam logic [7:0] CL = 8'h10;
  localparam logic [7:0] LD = 8'h08;
  localparam logic [7:0] BR = 8'h04;
  localparam logic [7:0] IN = 8'h02;
  localparam logic [7:0] CE = 8'h01;

  logic          clk = 1'b0;
  logic          rst_n, en, ld_pc, br_pc, inc_pc, call, ret, clr_err;
  logic [AW-1:0] pc_in, offset, pc_out;
  logic [2:0]    sp;
  logic          stack_full, stack_empty, ovf, unf;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_VEC(5'd0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld_pc(ld_pc), .br_pc(br_pc),
    .inc_pc(inc_pc), .call(call), .ret(ret), .clr_err(clr_err),
    .pc_in(pc_in), .offset(offset), .pc_out(pc_out), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         id;
    logic [4:0] pc;
    logic [2:0] sp;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   step_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step%0d: got=%0d want=%0d", name, id, got, want);
    end
  endtask

  // Monitor: pops expectations that fall due this cycle and checks them.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due != cyc) chk("late_check", e.id, cyc, e.due);
      chk("pc",    e.id, int'(pc_out),      int'(e.pc));
      chk("sp",    e.id, int'(sp),          int'(e.sp));
      chk("empty", e.id, int'(stack_empty), int'(e.sp == 3'd0));
      chk("full",  e.id, int'(stack_full),  int'(e.sp == 3'd4));
      chk("ovf",   e.id, int'(ovf),         int'(e.ovf));
      chk("unf",   e.id, int'(unf),         int'(e.unf));
    end
  end

  task automatic step(input logic [7:0] s, input logic [4:0] pin, input logic [4:0] off,
                      input logic [4:0] epc, input logic [2:0] esp,
                      input logic eo, input logic eu);
    exp_t e;
    {rst_n, en, ret, call, ld_pc, br_pc, inc_pc, clr_err} = s;
    pc_in  = pin;
    offset = off;
    step_id++;
    e.due = cyc + 1; e.id = step_id; e.pc = epc; e.sp = esp; e.ovf = eo; e.unf = eu;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset (with en=0, inc) then count and stall
    step(IN, 0, 0, 0, 0, 0, 0);
    step(IN, 0, 0, 0, 0, 0, 0);
    step(N|E|IN, 0, 0, 1, 0, 0, 0);
    step(N|E|IN, 0, 0, 2, 0, 0, 0);
    step(N|E|IN, 0, 0, 3, 0, 0, 0);
    step(N|IN,   0, 0, 3, 0, 0, 0);
    // 2. wrap and branch, then idle hold
    step(N|E|LD, 31, 0, 31, 0, 0, 0);
    step(N|E|IN, 0, 0, 0, 0, 0, 0);
    step(N|E|BR, 0, 5'b11110, 30, 0, 0, 0);
    step(N|E|BR, 0, 3, 1, 0, 0, 0);
    step(N|E,    0, 0, 1, 0, 0, 0);
    // 3. nested call/return
    step(N|E|LD, 4, 0, 4, 0, 0, 0);
    step(N|E|CL, 10, 0, 10, 1, 0, 0);
    step(N|E|CL, 20, 0, 20, 2, 0, 0);
    step(N|E|RT, 0, 0, 11, 1, 0, 0);
    step(N|E|RT, 0, 0, 5, 0, 0, 0);
    // 4. overflow: five calls from pc 0, then rets
    step(N|E|LD, 0, 0, 0, 0, 0, 0);
    step(N|E|CL, 1, 0, 1, 1, 0, 0);
    step(N|E|CL, 2, 0, 2, 2, 0, 0);
    step(N|E|CL, 3, 0, 3, 3, 0, 0);
    step(N|E|CL, 4, 0, 4, 4, 0, 0);
    step(N|E|CL, 5, 0, 5, 4, 1, 0);
`ifdef PC_STACK_WRAP_EN
    step(N|E|RT, 0, 0, 5, 3, 1, 0);
    step(N|E|RT, 0, 0, 4, 2, 1, 0);
    step(N|E|RT, 0, 0, 3, 1, 1, 0);
    step(N|E|RT, 0, 0, 2, 0, 1, 0);
    step(N|E|RT, 0, 0, 3, 0, 1, 1);
`else
    step(N|E|RT, 0, 0, 4, 3, 1, 0);
    step(N|E|RT, 0, 0, 3, 2, 1, 0);
    step(N|E|RT, 0, 0, 2, 1, 1, 0);
    step(N|E|RT, 0, 0, 1, 0, 1, 0);
    step(N|E|RT, 0, 0, 2, 0, 1, 1);
`endif
    // 5. underflow and sticky clear, including clear while stalled
    step(N|E|CE, 0, 0, `ifdef PC_STACK_WRAP_EN 3 `else 2 `endif, 0, 0, 0);
    step(N|E|LD, 7, 0, 7, 0, 0, 0);
    step(N|E|RT, 0, 0, 8, 0, 0, 1);
    step(N|E|RT|CE, 0, 0, 9, 0, 0, 1);
    step(N|E|CE, 0, 0, 9, 0, 0, 0);
    step(N|E|RT, 0, 0, 10, 0, 0, 1);
    step(N|CE|IN, 0, 0, 10, 0, 0, 0);
    // 6. priority, then reset during an active call
    step(N|E|LD, 8, 0, 8, 0, 0, 0);
    step(N|E|CL, 3, 0, 3, 1, 0, 0);
    step(N|E|RT|CL|LD|IN, 17, 0, 9, 0, 0, 0);
    step(N|E|CL, 12, 0, 12, 1, 0, 0);
    step(E|CL, 20, 0, 0, 0, 0, 0);
    step(N|E|RT, 0, 0, 1, 0, 0, 1);
    step(N|E|BR|IN, 0, 5'd4, 5, 0, 0, 1);

    {rst_n, en, ret, call, ld_pc, br_pc, inc_pc, clr_err} = N;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
